// File: rtl/mux_pkg.sv
// Shared constants for the multi-channel mux/arbiter slice.
package mux_pkg;

  localparam int MODO_FIXO = 0;
  localparam int MODO_RR   = 1;

  // Index width never drops below one bit, so N=1 still has a Sinal port.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_arb_arbitro_rr.sv
// Grant selection: first requester at or above the pointer (wrapping),
// or lowest index when round-robin is off.
module arbitro_rr
  import mux_pkg::*;
#(
  parameter  int N  = 3,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          mode_rr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int   start_i;
  int   chan_i;
  logic found;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    found   = 1'b0;
    chan_i  = 0;
    start_i = mode_rr ? int'(ptr) : 0;
    for (int k = 0; k < N; k++) begin
      chan_i = start_i + k;
      if (chan_i >= N) chan_i = chan_i - N;
      if (!found && req[chan_i]) begin
        found       = 1'b1;
        gnt[chan_i] = 1'b1;
        idx         = IW'(chan_i);
      end
    end
  end

endmodule

// File: rtl/mux_arb.sv
// N-channel arbitrated mux feeding a one-deep output register with
// valid/ready handshake; fixed-priority or round-robin grant.
module mux_arb
  import mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 3,
  parameter  int MODE  = MODO_FIXO,
  localparam int IW    = idx_w(N)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [N*WIDTH-1:0] Dado,
  input  logic [N-1:0]       Valido,
  output logic [N-1:0]       Pronto,
  output logic [WIDTH-1:0]   Saida,
  output logic               SaidaValida,
  input  logic               SaidaPronta,
  output logic [IW-1:0]      Sinal
);

  logic [WIDTH-1:0] saida_q, saida_d;
  logic [IW-1:0]    sinal_q, sinal_d;
  logic             valida_q, valida_d;
  logic [IW-1:0]    ptr_q, ptr_d;

  logic             load_en;
  logic             xfer;
  logic [N-1:0]     gnt;
  logic [IW-1:0]    gnt_idx;
  logic [WIDTH-1:0] dado_sel;

  arbitro_rr #(.N(N)) u_arb (
    .req     (Valido),
    .ptr     (ptr_q),
    .mode_rr (MODE == MODO_RR),
    .gnt     (gnt),
    .idx     (gnt_idx)
  );

  // Reset gates load so nothing is accepted while the slice is being cleared.
  assign load_en = !Reset && (!valida_q || SaidaPronta);
  assign Pronto  = load_en ? gnt : '0;
  assign xfer    = |Pronto;

  always_comb begin
    dado_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) dado_sel = dado_sel | Dado[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    saida_d  = saida_q;
    sinal_d  = sinal_q;
    valida_d = valida_q;
    ptr_d    = ptr_q;
    if (load_en) begin
      valida_d = xfer;
      if (xfer) begin
        saida_d = dado_sel;
        sinal_d = gnt_idx;
        if (MODE == MODO_RR) begin
          ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      saida_q  <= '0;
      sinal_q  <= '0;
      valida_q <= 1'b0;
      ptr_q    <= '0;
    end else begin
      saida_q  <= saida_d;
      sinal_q  <= sinal_d;
      valida_q <= valida_d;
      ptr_q    <= ptr_d;
    end
  end

  assign Saida       = saida_q;
  assign Sinal       = sinal_q;
  assign SaidaValida = valida_q;

endmodule

// File: tb/tb_mux_arb.sv
// Directed check of mux_arb: fixed-priority and round-robin instances share
// stimulus, each compared against hand-computed grants and outputs.
module tb_mux_arb;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [23:0] Dado;
  logic [2:0]  Valido;
  logic        SaidaPronta;

  logic [2:0]  pr_fp, pr_rr;
  logic [7:0]  sd_fp, sd_rr;
  logic        sv_fp, sv_rr;
  logic [1:0]  si_fp, si_rr;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  mux_arb #(.WIDTH(8), .N(3), .MODE(0)) u_fp (
    .Clock(Clock), .Reset(Reset), .Dado(Dado), .Valido(Valido),
    .Pronto(pr_fp), .Saida(sd_fp), .SaidaValida(sv_fp),
    .SaidaPronta(SaidaPronta), .Sinal(si_fp)
  );

  mux_arb #(.WIDTH(8), .N(3), .MODE(1)) u_rr (
    .Clock(Clock), .Reset(Reset), .Dado(Dado), .Valido(Valido),
    .Pronto(pr_rr), .Saida(sd_rr), .SaidaValida(sv_rr),
    .SaidaPronta(SaidaPronta), .Sinal(si_rr)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  vld;
    logic [23:0] dado;
    logic        sp;
    logic [2:0]  pr_fp;
    logic [2:0]  pr_rr;
    logic        ov_fp;
    logic [1:0]  os_fp;
    logic [7:0]  od_fp;
    logic        ov_rr;
    logic [1:0]  os_rr;
    logic [7:0]  od_rr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [2:0] vld,
                              input logic [23:0] dado, input logic sp,
                              input logic [2:0] pf, input logic [2:0] prr,
                              input logic vf, input logic [1:0] sf, input logic [7:0] df,
                              input logic vr, input logic [1:0] sr, input logic [7:0] dr);
    vec_t v;
    v.rst = rst; v.vld = vld; v.dado = dado; v.sp = sp;
    v.pr_fp = pf; v.pr_rr = prr;
    v.ov_fp = vf; v.os_fp = sf; v.od_fp = df;
    v.ov_rr = vr; v.os_rr = sr; v.od_rr = dr;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [2:0] vld,
                       input logic [23:0] dado, input logic sp);
    Reset = rst; Valido = vld; Dado = dado; SaidaPronta = sp;
  endtask

  localparam logic [23:0] DA = 24'hA2A1A0;

  initial begin
    //          rst vld     dado        sp   pr_fp   pr_rr   fp: v s  d      rr: v s  d
    vecs.push_back(mk(1, 3'b111, DA,         1, 3'b000, 3'b000, 0, 0, 8'h00, 0, 0, 8'h00));
    vecs.push_back(mk(1, 3'b111, DA,         1, 3'b000, 3'b000, 0, 0, 8'h00, 0, 0, 8'h00));
    vecs.push_back(mk(0, 3'b110, 24'h2211A0, 1, 3'b010, 3'b010, 1, 1, 8'h11, 1, 1, 8'h11));
    vecs.push_back(mk(0, 3'b111, DA,         1, 3'b001, 3'b100, 1, 0, 8'hA0, 1, 2, 8'hA2));
    vecs.push_back(mk(0, 3'b111, DA,         1, 3'b001, 3'b001, 1, 0, 8'hA0, 1, 0, 8'hA0));
    vecs.push_back(mk(0, 3'b111, DA,         1, 3'b001, 3'b010, 1, 0, 8'hA0, 1, 1, 8'hA1));
    vecs.push_back(mk(0, 3'b111, DA,         1, 3'b001, 3'b100, 1, 0, 8'hA0, 1, 2, 8'hA2));
    vecs.push_back(mk(0, 3'b111, DA,         1, 3'b001, 3'b001, 1, 0, 8'hA0, 1, 0, 8'hA0));
    // downstream stalls three cycles while the inputs keep changing
    vecs.push_back(mk(0, 3'b111, DA,         0, 3'b000, 3'b000, 1, 0, 8'hA0, 1, 0, 8'hA0));
    vecs.push_back(mk(0, 3'b111, 24'h998877, 0, 3'b000, 3'b000, 1, 0, 8'hA0, 1, 0, 8'hA0));
    vecs.push_back(mk(0, 3'b011, 24'h998877, 0, 3'b000, 3'b000, 1, 0, 8'hA0, 1, 0, 8'hA0));
    vecs.push_back(mk(0, 3'b001, 24'h332205, 1, 3'b001, 3'b001, 1, 0, 8'h05, 1, 0, 8'h05));
    vecs.push_back(mk(0, 3'b000, 24'h332205, 1, 3'b000, 3'b000, 0, 0, 8'h05, 0, 0, 8'h05));
    vecs.push_back(mk(0, 3'b000, 24'h332205, 0, 3'b000, 3'b000, 0, 0, 8'h05, 0, 0, 8'h05));
    vecs.push_back(mk(0, 3'b100, 24'h776655, 0, 3'b100, 3'b100, 1, 2, 8'h77, 1, 2, 8'h77));
    vecs.push_back(mk(0, 3'b111, DA,         1, 3'b001, 3'b001, 1, 0, 8'hA0, 1, 0, 8'hA0));
    vecs.push_back(mk(0, 3'b111, DA,         1, 3'b001, 3'b010, 1, 0, 8'hA0, 1, 1, 8'hA1));
    // reset mid-stream discards the held word and rewinds the pointer
    vecs.push_back(mk(1, 3'b111, DA,         1, 3'b000, 3'b000, 0, 0, 8'h00, 0, 0, 8'h00));
    vecs.push_back(mk(0, 3'b111, DA,         1, 3'b001, 3'b001, 1, 0, 8'hA0, 1, 0, 8'hA0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].dado, vecs[i].sp);
      #2;
      chk("pronto_fp", i, 16'(pr_fp), 16'(vecs[i].pr_fp));
      chk("pronto_rr", i, 16'(pr_rr), 16'(vecs[i].pr_rr));
      @(posedge Clock);
      #1;
      chk("out_fp", i, {5'd0, sv_fp, si_fp, sd_fp},
          {5'd0, vecs[i].ov_fp, vecs[i].os_fp, vecs[i].od_fp});
      chk("out_rr", i, {5'd0, sv_rr, si_rr, sd_rr},
          {5'd0, vecs[i].ov_rr, vecs[i].os_rr, vecs[i].od_rr});
    end

    // Round-robin skips the idle channel 1: pointer is 1 here, so 2,0,2,0.
    begin
      logic [1:0] exp_rr [4];
      exp_rr[0] = 2'd2; exp_rr[1] = 2'd0; exp_rr[2] = 2'd2; exp_rr[3] = 2'd0;
      for (int k = 0; k < 4; k++) begin
        drive(1'b0, 3'b101, 24'hC2C1C0, 1'b1);
        @(posedge Clock);
        #1;
        chk("skip_rr_sinal", k, 16'(si_rr), 16'(exp_rr[k]));
        chk("skip_rr_saida", k, 16'(sd_rr), (exp_rr[k] == 2'd2) ? 16'h00C2 : 16'h00C0);
        chk("skip_fp_sinal", k, 16'(si_fp), 16'd0);
      end
    end

    // Drain and refill in the same cycle: valid never drops across a burst.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 3'b010, 24'h00B100 + 24'(k), 1'b1);
      @(posedge Clock);
      #1;
      chk("burst_valid_fp", k, 16'(sv_fp), 16'd1);
      chk("burst_saida_fp", k, 16'(sd_fp), 16'h00B1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
